ip_tile_host_ctrl: RTL and testbench
====================================

// Module: ip_tile_host_ctrl
// PURPOSE
//  Host-side initiator for the IP-tile CSR/data-register interface.
//  - Accepts one command (CSR word + two operands) from a valid/ready requester.
//  - Drives the tile's csr_in, data_reg_a and data_reg_b, then waits for the tile to consume csr_in.
//  - Waits for the tile to post csr_out/data_reg_c, and returns them on a valid/ready response port.
//  - Sits between the SoC-side sequencer and any ip_tile_* user block.
// PARAMETERS
//  CSR_IN_WIDTH    16    width of csr_in / cmd_csr; MSB is the GO bit
//  CSR_OUT_WIDTH   16    width of csr_out / rsp_csr
//  REG_WIDTH       32    width of data_reg_a/b/c and cmd/rsp data
//  TIMEOUT_CYCLES  1024  watchdog limit, used only with IP_TILE_HOST_TIMEOUT_EN
// PORTS
//  clk         in   1              system clock, all logic on posedge
//  arst_n      in   1              synchronous active-low reset
//  cmd_valid   in   1              requester has a command
//  cmd_ready   out  1              controller accepts the command (high only in IDLE)
//  cmd_csr     in   CSR_IN_WIDTH   control word for the tile
//  cmd_a       in   REG_WIDTH      operand A
//  cmd_b       in   REG_WIDTH      operand B
//  rsp_valid   out  1              response available
//  rsp_ready   in   1              requester takes the response
//  rsp_csr     out  CSR_OUT_WIDTH  captured csr_out
//  rsp_c       out  REG_WIDTH      captured data_reg_c
//  rsp_err     out  1              response produced by watchdog timeout
//  busy        out  1              state != IDLE
//  csr_in      out  CSR_IN_WIDTH   to tile
//  csr_in_re   in   1              tile read-strobe: csr_in consumed
//  data_reg_a  out  REG_WIDTH      to tile
//  data_reg_b  out  REG_WIDTH      to tile
//  csr_out     in   CSR_OUT_WIDTH  from tile
//  csr_out_we  in   1              tile write-strobe: csr_out/data_reg_c valid this cycle
//  data_reg_c  in   REG_WIDTH      from tile
// BEHAVIOUR
//  - Reset (arst_n low at a posedge):
//    - state=IDLE.
//    - All outputs 0, except cmd_ready=1 once arst_n is high.
//    - Mid-operation reset clears csr_in at that edge, so the tile sees GO=0.
//  - FSM:
//    - IDLE:
//      - cmd_valid&cmd_ready -> ISSUE.
//      - Register csr_in = cmd_csr | (1<<CSR_IN_WIDTH-1), data_reg_a = cmd_a, data_reg_b = cmd_b.
//      - These appear one cycle after the handshake.
//    - ISSUE:
//      - Hold all tile outputs until csr_in_re=1.
//      - On that cycle: csr_in<=0 and -> WAIT_OUT.
//      - If csr_out_we=1 in the same cycle: capture csr_out/data_reg_c and -> RESP directly.
//    - WAIT_OUT:
//      - On csr_out_we=1: rsp_csr<=csr_out, rsp_c<=data_reg_c, -> RESP.
//      - data_reg_a/b are held until RESP exits.
//    - RESP:
//      - rsp_valid=1 with stable data.
//      - rsp_valid&rsp_ready -> IDLE, and data_reg_a/b <= 0.
//      - With rsp_ready tied high, RESP lasts 1 cycle; cmd_ready rises the next cycle.
//  - Ignored tile strobes:
//    - csr_in_re or csr_out_we in IDLE or RESP: ignored, no state change.
//    - csr_in_re in WAIT_OUT: ignored.
//  - Minimum latency: command handshake to rsp_valid is 2 cycles (tile strobes both in the first ISSUE cycle).
//  - One command in flight; no queuing. cmd_ready=0 outside IDLE.
// CONFIGURATION
//  IP_TILE_HOST_TIMEOUT_EN defined:
//   - A counter clears on entry to ISSUE and increments each cycle in ISSUE/WAIT_OUT.
//   - On reaching TIMEOUT_CYCLES: csr_in<=0, rsp_csr<=0, rsp_c<=0, rsp_err<=1, -> RESP.
//   - rsp_err clears on leaving RESP.
//   - A tile strobe in the same cycle as the timeout wins: normal capture, rsp_err=0.
//  IP_TILE_HOST_TIMEOUT_EN undefined:
//   - No counter; rsp_err is tied 0.
//   - The FSM waits indefinitely in ISSUE/WAIT_OUT.
// TESTING
//  1. Reset:
//     - Hold arst_n=0 for 3 clk -> all outputs 0, busy=0.
//     - Release -> cmd_ready=1.
//  2. Nominal:
//     - Stimulus: cmd_csr=16'h81F5, cmd_a=32'hA5A5A5A5, cmd_b=32'h12A2A3A5.
//       Tile model: csr_in_re 2 cycles after issue; csr_out_we with csr_out=16'h0001,
//       data_reg_c=32'h5A5A5A5A 5 cycles later.
//     - Response: csr_in=16'h81F5 until the re-strobe, then 0.
//       rsp_valid with rsp_csr=16'h0001, rsp_c=32'h5A5A5A5A, rsp_err=0.
//  3. Same-cycle strobes:
//     - Stimulus: csr_in_re and csr_out_we both in the first ISSUE cycle, csr_out=16'h00FF.
//     - Response: rsp_valid 2 cycles after the handshake, rsp_csr=16'h00FF.
//  4. Backpressure:
//     - Stimulus: rsp_ready=0 for 10 cycles.
//     - Response: rsp_valid, rsp_csr, rsp_c stable; cmd_ready=0 throughout.
//       A second cmd_valid is not accepted until 1 cycle after rsp_ready.
//  5. Timeout:
//     - Stimulus: build with macro, TIMEOUT_CYCLES=16, tile silent.
//     - Response: rsp_valid and rsp_err=1 16 cycles after ISSUE entry; csr_in=0.
//       Build without the macro: busy stays 1 for 100 cycles.
//  6. Reset mid-WAIT_OUT:
//     - Stimulus: arst_n=0 for 1 edge.
//     - Response: state IDLE and data_reg_a=0 at that edge.
//       A late csr_out_we after release is ignored; rsp_valid stays 0.

Source files
------------

// File: rtl/ip_tile_host_ctrl.sv
// ============================================================================
// ip_tile_host_ctrl : host-side initiator for the IP-tile CSR/data interface
// Optional watchdog: define IP_TILE_HOST_TIMEOUT_EN.       Revision: 1.0
// ============================================================================
`default_nettype none

module ip_tile_host_ctrl #(
  parameter int CSR_IN_WIDTH   = 16,
  parameter int CSR_OUT_WIDTH  = 16,
  parameter int REG_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [CSR_IN_WIDTH-1:0]  cmd_csr,
  input  logic [REG_WIDTH-1:0]     cmd_a,
  input  logic [REG_WIDTH-1:0]     cmd_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [CSR_OUT_WIDTH-1:0] rsp_csr,
  output logic [REG_WIDTH-1:0]     rsp_c,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [CSR_IN_WIDTH-1:0]  csr_in,
  input  logic                     csr_in_re,
  output logic [REG_WIDTH-1:0]     data_reg_a,
  output logic [REG_WIDTH-1:0]     data_reg_b,
  input  logic [CSR_OUT_WIDTH-1:0] csr_out,
  input  logic                     csr_out_we,
  input  logic [REG_WIDTH-1:0]     data_reg_c
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_OUT = 2'd2,
    S_RESP     = 2'd3
  } state_e;

  localparam logic [CSR_IN_WIDTH-1:0] C_GO_MASK = {1'b1, {(CSR_IN_WIDTH-1){1'b0}}};

  state_e                   state_q;
  logic [CSR_IN_WIDTH-1:0]  csr_in_q;
  logic [REG_WIDTH-1:0]     reg_a_q;
  logic [REG_WIDTH-1:0]     reg_b_q;
  logic [CSR_OUT_WIDTH-1:0] rsp_csr_q;
  logic [REG_WIDTH-1:0]     rsp_c_q;
  logic                     rsp_err_q;
  logic                     timeout_hit;

`ifdef IP_TILE_HOST_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  // Counter sits at zero in IDLE, so it is clear on the first ISSUE cycle.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      cnt_q <= '0;
    end else if (state_q == S_ISSUE || state_q == S_WAIT_OUT) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q   <= S_IDLE;
      csr_in_q  <= '0;
      reg_a_q   <= '0;
      reg_b_q   <= '0;
      rsp_csr_q <= '0;
      rsp_c_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            csr_in_q <= cmd_csr | C_GO_MASK;
            reg_a_q  <= cmd_a;
            reg_b_q  <= cmd_b;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // A tile strobe always beats a watchdog expiry in the same cycle.
          if (csr_in_re) begin
            csr_in_q <= '0;
            if (csr_out_we) begin
              rsp_csr_q <= csr_out;
              rsp_c_q   <= data_reg_c;
              rsp_err_q <= 1'b0;
              state_q   <= S_RESP;
            end else begin
              state_q <= S_WAIT_OUT;
            end
          end else if (timeout_hit) begin
            csr_in_q  <= '0;
            rsp_csr_q <= '0;
            rsp_c_q   <= '0;
            rsp_err_q <= 1'b1;
            state_q   <= S_RESP;
          end
        end
        S_WAIT_OUT: begin
          if (csr_out_we) begin
            rsp_csr_q <= csr_out;
            rsp_c_q   <= data_reg_c;
            rsp_err_q <= 1'b0;
            state_q   <= S_RESP;
          end else if (timeout_hit) begin
            csr_in_q  <= '0;
            rsp_csr_q <= '0;
            rsp_c_q   <= '0;
            rsp_err_q <= 1'b1;
            state_q   <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            reg_a_q   <= '0;
            reg_b_q   <= '0;
            rsp_err_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = (state_q == S_IDLE) && arst_n;
  assign busy       = (state_q != S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_csr    = rsp_csr_q;
  assign rsp_c      = rsp_c_q;
  assign rsp_err    = rsp_err_q;
  assign csr_in     = csr_in_q;
  assign data_reg_a = reg_a_q;
  assign data_reg_b = reg_b_q;

endmodule

`default_nettype wire

// File: tb/tb_ip_tile_host_ctrl.sv
// ============================================================================
// tb_ip_tile_host_ctrl : scoreboard bench for ip_tile_host_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ip_tile_host_ctrl;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_csr;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_csr;
  logic [31:0] rsp_c;
  logic        rsp_err;
  logic        busy;
  logic [15:0] csr_in;
  logic        csr_in_re;
  logic [31:0] data_reg_a;
  logic [31:0] data_reg_b;
  logic [15:0] csr_out;
  logic        csr_out_we;
  logic [31:0] data_reg_c;

  int total = 0;
  int bad   = 0;
  logic [48:0] sb[$];   // {err, csr, c}

  always #5 clk = ~clk;

  ip_tile_host_ctrl #(
    .CSR_IN_WIDTH  (16),
    .CSR_OUT_WIDTH (16),
    .REG_WIDTH     (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_csr   (cmd_csr),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_csr   (rsp_csr),
    .rsp_c     (rsp_c),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .csr_in    (csr_in),
    .csr_in_re (csr_in_re),
    .data_reg_a(data_reg_a),
    .data_reg_b(data_reg_b),
    .csr_out   (csr_out),
    .csr_out_we(csr_out_we),
    .data_reg_c(data_reg_c)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [15:0] c, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_csr   = c;
    cmd_a     = a;
    cmd_b     = b;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_ready) chk("cmd_accept_timeout", 64'd0, 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic check_rsp(input int maxc);
    int n = 0;
    logic [48:0] e;
    while (!rsp_valid && n < maxc) begin
      tick();
      n++;
    end
    if (!rsp_valid) begin
      chk("rsp_wait_timeout", 64'd0, 64'd1);
    end else if (sb.size() == 0) begin
      chk("rsp_unexpected", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk("rsp_err", rsp_err, e[48]);
      chk("rsp_csr", rsp_csr, e[47:32]);
      chk("rsp_c",   rsp_c,   e[31:0]);
    end
  endtask

  task automatic strobe_both(input logic [15:0] co, input logic [31:0] dc);
    csr_in_re  = 1'b1;
    csr_out_we = 1'b1;
    csr_out    = co;
    data_reg_c = dc;
    tick();
    csr_in_re  = 1'b0;
    csr_out_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    arst_n = 1'b0; cmd_valid = 1'b0; cmd_csr = '0; cmd_a = '0; cmd_b = '0;
    rsp_ready = 1'b0; csr_in_re = 1'b0; csr_out_we = 1'b0; csr_out = '0; data_reg_c = '0;

    // Reset
    repeat (3) tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy",      busy, 0);
    chk("rst_csr_in",    csr_in, 0);
    chk("rst_reg_a",     data_reg_a, 0);
    chk("rst_reg_b",     data_reg_b, 0);
    chk("rst_rsp_csr",   rsp_csr, 0);
    chk("rst_rsp_c",     rsp_c, 0);
    chk("rst_rsp_err",   rsp_err, 0);
    arst_n = 1'b1;
    #1;
    chk("rel_cmd_ready", cmd_ready, 1);

    // Nominal
    rsp_ready = 1'b1;
    sb.push_back({1'b0, 16'h0001, 32'h5A5A5A5A});
    do_cmd(16'h81F5, 32'hA5A5A5A5, 32'h12A2A3A5);
    chk("nom_csr_in",    csr_in, 16'h81F5);
    chk("nom_reg_a",     data_reg_a, 32'hA5A5A5A5);
    chk("nom_reg_b",     data_reg_b, 32'h12A2A3A5);
    chk("nom_busy",      busy, 1);
    chk("nom_cmd_ready", cmd_ready, 0);
    tick();
    chk("nom_csr_hold",  csr_in, 16'h81F5);
    csr_in_re = 1'b1;
    tick();
    csr_in_re = 1'b0;
    chk("nom_csr_clear", csr_in, 0);
    chk("nom_a_hold",    data_reg_a, 32'hA5A5A5A5);
    repeat (4) tick();
    chk("nom_no_rsp",    rsp_valid, 0);
    csr_out_we = 1'b1; csr_out = 16'h0001; data_reg_c = 32'h5A5A5A5A;
    tick();
    csr_out_we = 1'b0;
    check_rsp(4);
    tick();
    chk("nom_ready_after", cmd_ready, 1);
    chk("nom_a_cleared",   data_reg_a, 0);
    chk("nom_b_cleared",   data_reg_b, 0);

    // Same-cycle strobes, GO bit forced
    sb.push_back({1'b0, 16'h00FF, 32'hC3C3C3C3});
    do_cmd(16'h0012, 32'h1, 32'h2);
    chk("same_csr_go", csr_in, 16'h8012);
    strobe_both(16'h00FF, 32'hC3C3C3C3);
    chk("same_rsp_valid", rsp_valid, 1);
    check_rsp(1);
    tick();

    // Backpressure with a second command waiting
    rsp_ready = 1'b0;
    sb.push_back({1'b0, 16'h0ABC, 32'hDEADBEEF});
    do_cmd(16'h0003, 32'd10, 32'd20);
    strobe_both(16'h0ABC, 32'hDEADBEEF);
    cmd_valid = 1'b1; cmd_csr = 16'h0044; cmd_a = 32'd30; cmd_b = 32'd40;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid",     rsp_valid, 1);
      chk("bp_csr",       rsp_csr, 16'h0ABC);
      chk("bp_c",         rsp_c, 32'hDEADBEEF);
      chk("bp_cmd_ready", cmd_ready, 0);
      tick();
    end
    check_rsp(1);
    rsp_ready = 1'b1;
    sb.push_back({1'b0, 16'h0055, 32'h11112222});
    tick();
    chk("bp_idle_ready", cmd_ready, 1);
    chk("bp_idle_busy",  busy, 0);
    chk("bp_a_cleared",  data_reg_a, 0);
    tick();
    cmd_valid = 1'b0;
    chk("bp2_busy",   busy, 1);
    chk("bp2_csr_in", csr_in, 16'h8044);
    chk("bp2_reg_a",  data_reg_a, 32'd30);
    strobe_both(16'h0055, 32'h11112222);
    check_rsp(1);
    tick();

`ifdef IP_TILE_HOST_TIMEOUT_EN
    sb.push_back({1'b1, 16'h0000, 32'h00000000});
    do_cmd(16'h0100, 32'd5, 32'd6);
    repeat (15) tick();
    chk("to_early", rsp_valid, 0);
    tick();
    chk("to_valid",  rsp_valid, 1);
    chk("to_csr_in", csr_in, 0);
    check_rsp(1);
    tick();
    chk("to_err_clear", rsp_err, 0);
    chk("to_idle",      busy, 0);
    do_cmd(16'h0200, 32'd7, 32'd8);
`else
    do_cmd(16'h0100, 32'd5, 32'd6);
    repeat (100) tick();
    chk("noto_busy",  busy, 1);
    chk("noto_valid", rsp_valid, 0);
`endif
    csr_in_re = 1'b1;
    tick();
    csr_in_re = 1'b0;

    // Reset while in WAIT_OUT
    chk("wo_busy",   busy, 1);
    chk("wo_csr_in", csr_in, 0);
    arst_n = 1'b0;
    tick();
    chk("mrst_busy",      busy, 0);
    chk("mrst_reg_a",     data_reg_a, 0);
    chk("mrst_cmd_ready", cmd_ready, 0);
    arst_n = 1'b1;
    csr_out_we = 1'b1; csr_out = 16'h0077; data_reg_c = 32'h99;
    tick();
    csr_out_we = 1'b0;
    chk("late_rsp_valid", rsp_valid, 0);
    chk("late_busy",      busy, 0);
    chk("late_cmd_ready", cmd_ready, 1);
    chk("sb_empty",       sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
